// File: rtl/input_conditioner.sv
// Board-input receive path: polarity normalization, two-flop synchronizer, per-channel
// debounce with press/release strobes, and a single-entry event register for the core.
module input_conditioner #(
  parameter int           N       = 5,
  parameter int           DEB     = 20,
  parameter int           CNT_W   = 5,
  parameter logic [N-1:0] ACT_LOW = 5'b00111
) (
  input  logic         CLK1K,
  input  logic         RSTN,
  input  logic [N-1:0] RAW_IN,
  output logic [N-1:0] LEVEL,
  output logic [N-1:0] PRESS,
  output logic [N-1:0] RELEASE,
  output logic         EVT_VALID,
  output logic [2:0]   EVT_ID,
  output logic         EVT_EDGE,
  output logic         EVT_OVF,
  input  logic         EVT_ACK
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB - 1);

  logic [N-1:0]     s1_p0;
  logic [N-1:0]     s2_p1;
  logic [CNT_W-1:0] cnt_p2 [N];

  logic [N-1:0] strobe;
  logic [2:0]   cand_id;
  logic         cand;
  logic         multi;
  logic         slot_free;
  logic         ack_ok;
  logic         drop;

  function automatic logic [2:0] lowest_idx(input logic [N-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Stage p0/p1: normalize to active-high and synchronize
  always_ff @(posedge CLK1K) begin
    if (!RSTN) begin
      s1_p0 <= '0;
      s2_p1 <= '0;
    end else begin
      s1_p0 <= RAW_IN ^ ACT_LOW;
      s2_p1 <= s1_p0;
    end
  end

  // Stage p2: debounce; a new level is accepted after DEB consecutive disagreeing samples
  always_ff @(posedge CLK1K) begin
    if (!RSTN) begin
      LEVEL   <= '0;
      PRESS   <= '0;
      RELEASE <= '0;
      for (int i = 0; i < N; i++) cnt_p2[i] <= '0;
    end else begin
      PRESS   <= '0;
      RELEASE <= '0;
      for (int i = 0; i < N; i++) begin
        if (s2_p1[i] == LEVEL[i]) begin
          cnt_p2[i] <= '0;
        end else if (cnt_p2[i] == CNT_LAST) begin
          LEVEL[i]   <= s2_p1[i];
          cnt_p2[i]  <= '0;
          PRESS[i]   <= s2_p1[i];
          RELEASE[i] <= !s2_p1[i];
        end else begin
          cnt_p2[i] <= cnt_p2[i] + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    strobe    = PRESS | RELEASE;
    cand      = |strobe;
    cand_id   = lowest_idx(strobe);
    multi     = (strobe & (strobe - N'(1))) != '0;
    ack_ok    = EVT_ACK && EVT_VALID;
    slot_free = !EVT_VALID || EVT_ACK;
    drop      = cand && (!slot_free || multi);
  end

  // Stage p3: capture the lowest-index registered strobe into the event slot
  always_ff @(posedge CLK1K) begin
    if (!RSTN) begin
      EVT_VALID <= 1'b0;
      EVT_ID    <= '0;
      EVT_EDGE  <= 1'b0;
      EVT_OVF   <= 1'b0;
    end else begin
      if (cand && slot_free) begin
        EVT_VALID <= 1'b1;
        EVT_ID    <= cand_id;
        EVT_EDGE  <= PRESS[cand_id];
      end else if (ack_ok) begin
        EVT_VALID <= 1'b0;
      end
      if (drop) begin
        EVT_OVF <= 1'b1;
      end else if (ack_ok) begin
        EVT_OVF <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a window-based behavioural model.
module tb_input_conditioner;

  localparam int           N       = 5;
  localparam int           DEB     = 20;
  localparam logic [N-1:0] ACT_LOW = 5'b00111;
  localparam logic [DEB-1:0] ONES  = '1;
  localparam logic [DEB-1:0] ZEROS = '0;

  logic         clk;
  logic         rstn;
  logic [N-1:0] raw;
  logic [N-1:0] level, press, release_s;
  logic         evt_valid, evt_edge, evt_ovf, evt_ack;
  logic [2:0]   evt_id;

  int checks = 0;
  int errors = 0;

  input_conditioner #(.N(N), .DEB(DEB), .CNT_W(5), .ACT_LOW(ACT_LOW)) dut (
    .CLK1K(clk), .RSTN(rstn), .RAW_IN(raw), .LEVEL(level), .PRESS(press),
    .RELEASE(release_s), .EVT_VALID(evt_valid), .EVT_ID(evt_id), .EVT_EDGE(evt_edge),
    .EVT_OVF(evt_ovf), .EVT_ACK(evt_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: each channel keeps its last DEB synchronized samples; the level
  // flips when the whole window disagrees with it. Events follow the strobes one edge later.
  logic [N-1:0]   m_s1, m_s2, m_level, m_press, m_rel;
  logic [DEB-1:0] win [N];
  logic           m_valid, m_edge, m_ovf, m_ok;
  logic [2:0]     m_id;

  initial m_ok = 1'b0;

  always @(posedge clk) begin : model
    logic [N-1:0] strb;
    int           n, k;
    logic         found, ackok, sfree, drp;
    if (!rstn) begin
      m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_rel = '0;
      m_valid = 0; m_edge = 0; m_ovf = 0; m_id = '0;
      for (int i = 0; i < N; i++) win[i] = '0;
      m_ok = 1'b1;
    end else begin
      strb  = m_press | m_rel;
      n     = $countones(strb);
      found = 0;
      k     = 0;
      for (int i = 0; i < N; i++) begin
        if (strb[i] && !found) begin
          found = 1;
          k     = i;
        end
      end
      ackok = evt_ack && m_valid;
      sfree = !m_valid || evt_ack;
      drp   = (n > 0) && (!sfree || n > 1);
      if (n > 0 && sfree) begin
        m_valid = 1;
        m_id    = 3'(k);
        m_edge  = m_press[k];
      end else if (ackok) begin
        m_valid = 0;
      end
      if (drp) m_ovf = 1;
      else if (ackok) m_ovf = 0;

      for (int i = 0; i < N; i++) begin
        win[i]     = {win[i][DEB-2:0], m_s2[i]};
        m_press[i] = 0;
        m_rel[i]   = 0;
        if (win[i] == (m_level[i] ? ZEROS : ONES)) begin
          m_level[i] = ~m_level[i];
          m_press[i] = m_level[i];
          m_rel[i]   = ~m_level[i];
        end
      end
      m_s2 = m_s1;
      m_s1 = raw ^ ACT_LOW;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_level",   32'(level),     32'(m_level));
      chk("m_press",   32'(press),     32'(m_press));
      chk("m_release", 32'(release_s), 32'(m_rel));
      chk("m_valid",   32'(evt_valid), 32'(m_valid));
      chk("m_id",      32'(evt_id),    32'(m_id));
      chk("m_edge",    32'(evt_edge),  32'(m_edge));
      chk("m_ovf",     32'(evt_ovf),   32'(m_ovf));
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cnt(input int n, input int ch, output int pc, output int rc);
    pc = 0;
    rc = 0;
    repeat (n) begin
      @(negedge clk);
      pc += int'(press[ch]);
      rc += int'(release_s[ch]);
    end
  endtask

  task automatic ack_pulse();
    evt_ack = 1'b1;
    wait_n(1);
    evt_ack = 1'b0;
  endtask

  task automatic drain();
    wait_n(25);
    ack_pulse();
  endtask

  initial begin
    int pc, rc, tp, tr;
    rstn    = 1'b0;
    raw     = ACT_LOW;
    evt_ack = 1'b0;
    wait_n(3);
    rstn = 1'b1;
    chk("rst_level", 32'(level), 0);
    chk("rst_strobes", 32'(press | release_s), 0);
    chk("rst_evt", 32'({evt_valid, evt_id, evt_edge, evt_ovf}), 0);
    wait_n(5);

    // KEY1 clean press
    raw[0] = 1'b0;
    wait_n(21);
    chk("k1_level_early", 32'(level), 0);
    wait_n(1);
    chk("k1_press", 32'(press), 32'h01);
    chk("k1_level", 32'(level), 32'h01);
    chk("k1_valid_early", 32'(evt_valid), 0);
    wait_n(1);
    chk("k1_evt", 32'({evt_valid, evt_id, evt_edge}), 32'b1_000_1);
    chk("k1_press_gone", 32'(press), 0);
    ack_pulse();
    chk("k1_ack", 32'(evt_valid), 0);
    raw[0] = 1'b1;
    drain();

    // TOUCH bouncing every 5 cycles, then held
    tp = 0;
    tr = 0;
    for (int s = 0; s < 12; s++) begin
      raw[3] = ~raw[3];
      wait_cnt(5, 3, pc, rc);
      tp += pc;
      tr += rc;
    end
    raw[3] = 1'b1;
    wait_cnt(21, 3, pc, rc);
    chk("touch_bounce_strobes", 32'(tp + tr + pc + rc), 0);
    wait_n(1);
    chk("touch_press", 32'(press), 32'h08);
    wait_n(1);
    chk("touch_evt_id", 32'(evt_id), 3);
    ack_pulse();
    raw[3] = 1'b0;
    drain();

    // Pending event, KEY2 press and release both dropped
    raw[0] = 1'b0;
    wait_n(23);
    raw[1] = 1'b0;
    wait_n(30);
    raw[1] = 1'b1;
    wait_n(30);
    chk("ovf_set", 32'({evt_valid, evt_id, evt_edge, evt_ovf}), 32'b1_000_1_1);
    ack_pulse();
    chk("ovf_ack", 32'({evt_valid, evt_ovf}), 0);
    raw[0] = 1'b1;
    drain();

    // KEY1 + KEY3 together, then ack coinciding with RELEASE[2]
    raw[0] = 1'b0;
    raw[2] = 1'b0;
    wait_n(23);
    chk("dual_evt", 32'({evt_valid, evt_id, evt_edge, evt_ovf}), 32'b1_000_1_1);
    raw[2] = 1'b1;
    wait_n(22);
    chk("k3_release", 32'(release_s), 32'h04);
    ack_pulse();
    chk("ack_and_new", 32'({evt_valid, evt_id, evt_edge, evt_ovf}), 32'b1_010_0_0);
    raw[0] = 1'b1;
    wait_n(25);

    // Reset in the middle of a KEY3 debounce, with an event and overflow pending
    raw[2] = 1'b0;
    wait_n(17);
    rstn = 1'b0;
    wait_n(1);
    rstn = 1'b1;
    chk("midrst_level", 32'(level), 0);
    chk("midrst_strobes", 32'(press | release_s), 0);
    chk("midrst_evt", 32'({evt_valid, evt_id, evt_edge, evt_ovf}), 0);
    wait_n(21);
    chk("postrst_level_early", 32'(level), 0);
    wait_n(1);
    chk("postrst_press", 32'(press), 32'h04);
    wait_n(1);
    ack_pulse();
    raw[2] = 1'b1;
    drain();

    // SOUNDSENSOR: short pulse rejected, long pulse accepted once each way
    raw[4] = 1'b1;
    wait_cnt(10, 4, tp, tr);
    raw[4] = 1'b0;
    wait_cnt(40, 4, pc, rc);
    chk("snd_short_strobes", 32'(tp + tr + pc + rc), 0);
    chk("snd_short_level", 32'(level[4]), 0);
    raw[4] = 1'b1;
    wait_cnt(30, 4, tp, tr);
    raw[4] = 1'b0;
    wait_cnt(60, 4, pc, rc);
    chk("snd_long_press", 32'(tp + pc), 1);
    chk("snd_long_release", 32'(tr + rc), 1);
    ack_pulse();
    ack_pulse();

    // Randomized phase
    for (int c = 0; c < 5000; c++) begin
      for (int ch = 0; ch < N; ch++) begin
        if ($urandom_range(0, 29) == 0) raw[ch] = ~raw[ch];
      end
      evt_ack = ($urandom_range(0, 3) == 0);
      rstn    = ($urandom_range(0, 799) != 0);
      wait_n(1);
    end
    rstn    = 1'b1;
    evt_ack = 1'b0;
    wait_n(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
